// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer for the single-port byte-addressed data memory.
// Serialises accesses as IDLE -> ACCESS -> RESP and returns checked responses.
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES  = 1024,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [2:0]  m0_size,
    input  logic        m0_sign,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic        m0_err,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [2:0]  m1_size,
    input  logic        m1_sign,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic        m1_err,
    output logic [31:0] m1_rdata,

    output logic [31:0] mem_result,
    output logic [31:0] mem_data,
    output logic        mem_store,
    output logic        mem_load,
    output logic [2:0]  mem_size,
    output logic        mem_sign,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state, state_next;

    logic        cap_we;
    logic        cap_sign;
    logic        cap_owner;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [2:0]  cap_size;
    logic        rr_last;
    logic        err_q;

    logic        any_req;
    logic        winner;
    logic        grant;
    logic        size_bad;
    logic        misaligned;
    logic        out_of_range;
    logic        acc_err;
    logic [32:0] end_addr;
    logic        resp;
    logic        good_load;

    // Arbitration: single requester wins outright; a tie goes to the fixed
    // favourite or to whichever master did not win last time.
    always_comb begin
        any_req = m0_req | m1_req;
        if (m0_req && m1_req) begin
            winner = FIXED_PRIO ? 1'b0 : ~rr_last;
        end else begin
            winner = m1_req;
        end
        grant  = rst_n && (state == IDLE) && any_req;
        m0_gnt = grant && !winner;
        m1_gnt = grant && winner;
    end

    // Access check on the captured request; 33-bit end address avoids wrap.
    always_comb begin
        size_bad   = 1'b1;
        misaligned = 1'b0;
        case (cap_size)
            3'd1: size_bad = 1'b0;
            3'd2: begin
                size_bad   = 1'b0;
                misaligned = cap_addr[0];
            end
            3'd4: begin
                size_bad   = 1'b0;
                misaligned = |cap_addr[1:0];
            end
            default: size_bad = 1'b1;
        endcase
        end_addr     = {1'b0, cap_addr} + 33'(cap_size);
        out_of_range = end_addr > 33'(MEM_BYTES);
        acc_err      = size_bad || misaligned || out_of_range;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = any_req ? ACCESS : IDLE;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_result = cap_addr;
        mem_data   = cap_wdata;
        mem_size   = cap_size;
        mem_sign   = cap_sign;
        mem_store  = (state == ACCESS) && !acc_err && cap_we;
        mem_load   = (state == ACCESS) && !acc_err && !cap_we;

        resp       = (state == RESP);
        good_load  = !err_q && !cap_we;
        m0_rvalid  = resp && !cap_owner;
        m1_rvalid  = resp && cap_owner;
        m0_err     = m0_rvalid && err_q;
        m1_err     = m1_rvalid && err_q;
        m0_rdata   = (m0_rvalid && good_load) ? mem_rdata : '0;
        m1_rdata   = (m1_rvalid && good_load) ? mem_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_last   <= 1'b1;
            cap_we    <= 1'b0;
            cap_sign  <= 1'b0;
            cap_owner <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_size  <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_next;
            if (grant) begin
                rr_last   <= winner;
                cap_owner <= winner;
                cap_we    <= winner ? m1_we    : m0_we;
                cap_addr  <= winner ? m1_addr  : m0_addr;
                cap_wdata <= winner ? m1_wdata : m0_wdata;
                cap_size  <= winner ? m1_size  : m0_size;
                cap_sign  <= winner ? m1_sign  : m0_sign;
            end
            if (state == ACCESS) begin
                err_q <= acc_err;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte memory stand-in plus a transaction-level
// reference model (timeline of grants, strobes and responses, shadow memory).
module tb_dmem_arbiter;

    localparam int unsigned MEM_BYTES  = 1024;
    localparam bit          FIXED_PRIO = 1'b0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        rq [2];
    logic        rwe[2];
    logic        rsg[2];
    logic [31:0] rad[2];
    logic [31:0] rwd[2];
    logic [2:0]  rsz[2];

    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_result, mem_data;
    logic        mem_store, mem_load, mem_sign;
    logic [2:0]  mem_size;
    logic [31:0] mem_rdata = '0;

    dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .FIXED_PRIO(FIXED_PRIO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(rq[0]), .m0_we(rwe[0]), .m0_addr(rad[0]), .m0_wdata(rwd[0]),
        .m0_size(rsz[0]), .m0_sign(rsg[0]), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(rq[1]), .m1_we(rwe[1]), .m1_addr(rad[1]), .m1_wdata(rwd[1]),
        .m1_size(rsz[1]), .m1_sign(rsg[1]), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_err(m1_err), .m1_rdata(m1_rdata),
        .mem_result(mem_result), .mem_data(mem_data), .mem_store(mem_store),
        .mem_load(mem_load), .mem_size(mem_size), .mem_sign(mem_sign),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] size,
                                           input logic sign);
        case (size)
            3'd1:    return sign ? {{24{raw[7]}}, raw[7:0]} : {24'h0, raw[7:0]};
            3'd2:    return sign ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    // Memory stand-in: little-endian bytes, read data registered one cycle.
    logic [7:0] env_mem [MEM_BYTES] = '{default: 8'h00};

    function automatic logic [31:0] env_raw(input logic [31:0] a);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = env_mem[int'((a + 32'(i)) % MEM_BYTES)];
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_store) begin
            for (int i = 0; i < 4; i++) begin
                if (i < int'(mem_size))
                    env_mem[int'((mem_result + 32'(i)) % MEM_BYTES)] <= mem_data[8*i +: 8];
            end
        end
        if (mem_load) mem_rdata <= extend(env_raw(mem_result), mem_size, mem_sign);
    end

    // Reference model state
    logic [7:0]  ref_mem [MEM_BYTES] = '{default: 8'h00};
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          next_free = 0;
    int          last_w = 1;
    int          st_cyc = -1;
    logic [1:0]  st_val;
    logic [31:0] st_addr, st_data;
    logic [3:0]  st_ss;
    int          rs_cyc = -1;
    int          rs_m;
    logic        rs_err;
    logic [31:0] rs_data;

    logic        got_rv [2];
    logic        got_err[2];
    logic [31:0] got_data[2];
    logic        gnt_seen[2];
    int          gnt_cyc[2];
    int          rv_cyc[2];
    int          rv_cnt = 0;
    int          strobe_cnt = 0;
    bit          keep_req = 1'b0;
    int          glog_m[$];
    int          glog_c[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic access_err(input logic [31:0] addr, input logic [2:0] size);
        if (!(size == 3'd1 || size == 3'd2 || size == 3'd4)) return 1'b1;
        if ((addr % 32'(size)) != 0) return 1'b1;
        if (longint'(addr) + longint'(size) > longint'(MEM_BYTES)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] size,
                                             input logic sign);
        logic [31:0] raw;
        raw = '0;
        for (int i = 0; i < 4; i++) if (i < int'(size)) raw[8*i +: 8] = ref_mem[int'(addr) + i];
        return extend(raw, size, sign);
    endfunction

    // One clock cycle: inputs already applied; predict, compare, advance.
    task automatic step();
        logic [1:0]  eg, es, og;
        logic [33:0] e0, e1;
        int          w;
        logic        berr;
        #1;
        eg = '0;
        w  = 0;
        if (rst_n && cyc >= next_free && (rq[0] || rq[1])) begin
            if (rq[0] && rq[1]) w = FIXED_PRIO ? 0 : 1 - last_w;
            else                w = rq[1] ? 1 : 0;
            eg[w] = 1'b1;
        end
        es = (cyc == st_cyc) ? st_val : 2'b00;
        e0 = '0;
        e1 = '0;
        if (cyc == rs_cyc) begin
            if (rs_m == 0) e0 = {1'b1, rs_err, rs_data};
            else           e1 = {1'b1, rs_err, rs_data};
        end
        if (cyc > 0) begin
            check("gnt", 64'({m1_gnt, m0_gnt}), 64'(eg));
            check("strobe", 64'({mem_store, mem_load}), 64'(es));
            check("resp0", 64'({m0_rvalid, m0_err, m0_rdata}), 64'(e0));
            check("resp1", 64'({m1_rvalid, m1_err, m1_rdata}), 64'(e1));
            if (es != 2'b00) begin
                check("mem_addr", 64'(mem_result), 64'(st_addr));
                check("mem_size_sign", 64'({mem_size, mem_sign}), 64'(st_ss));
                if (es == 2'b10) check("mem_data", 64'(mem_data), 64'(st_data));
            end
        end
        og = {m1_gnt, m0_gnt};
        if (mem_store || mem_load) strobe_cnt++;
        for (int m = 0; m < 2; m++) begin
            if (og[m]) begin
                gnt_seen[m] = 1'b1;
                gnt_cyc[m]  = cyc;
                glog_m.push_back(m);
                glog_c.push_back(cyc);
            end
        end
        if (m0_rvalid) begin
            got_rv[0] = 1'b1; got_err[0] = m0_err; got_data[0] = m0_rdata;
            rv_cyc[0] = cyc; rv_cnt++;
        end
        if (m1_rvalid) begin
            got_rv[1] = 1'b1; got_err[1] = m1_err; got_data[1] = m1_rdata;
            rv_cyc[1] = cyc; rv_cnt++;
        end
        if (eg != 2'b00) begin
            berr    = access_err(rad[w], rsz[w]);
            st_cyc  = cyc + 1;
            st_val  = berr ? 2'b00 : (rwe[w] ? 2'b10 : 2'b01);
            st_addr = rad[w];
            st_data = rwd[w];
            st_ss   = {rsz[w], rsg[w]};
            rs_cyc  = cyc + 2;
            rs_m    = w;
            rs_err  = berr;
            rs_data = (berr || rwe[w]) ? 32'h0 : ref_load(rad[w], rsz[w], rsg[w]);
            if (!berr && rwe[w]) begin
                for (int i = 0; i < int'(rsz[w]); i++) ref_mem[int'(rad[w]) + i] = rwd[w][8*i +: 8];
            end
            next_free = cyc + 3;
            last_w    = w;
        end
        if (!rst_n) begin
            next_free = cyc + 1;
            last_w    = 1;
            st_cyc    = -1;
            rs_cyc    = -1;
        end
        @(negedge clk);
        cyc++;
        for (int m = 0; m < 2; m++) if (og[m] && !keep_req) rq[m] = 1'b0;
    endtask

    task automatic issue(input int m, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [2:0] sz, input logic sg);
        rq[m] = 1'b1; rwe[m] = we; rad[m] = addr; rwd[m] = wd; rsz[m] = sz; rsg[m] = sg;
        got_rv[m] = 1'b0;
        gnt_seen[m] = 1'b0;
    endtask

    task automatic wait_resp(input int m, input string tag);
        for (int i = 0; i < 20 && !got_rv[m]; i++) step();
        check({tag, "_done"}, 64'(got_rv[m]), 64'(1));
    endtask

    task automatic gen(input int m);
        int r;
        r = int'($urandom_range(0, 15));
        case (r)
            0:       rsz[m] = 3'd3;
            1:       rsz[m] = 3'd0;
            2, 3, 4: rsz[m] = 3'd1;
            5, 6, 7: rsz[m] = 3'd2;
            default: rsz[m] = 3'd4;
        endcase
        r = int'($urandom_range(0, 31));
        if (r == 0)      rad[m] = 32'hFFFF_FFFC;
        else if (r < 5)  rad[m] = $urandom_range(MEM_BYTES - 8, MEM_BYTES + 8);
        else             rad[m] = $urandom_range(0, 63);
        rwe[m] = 1'($urandom_range(0, 1));
        rsg[m] = 1'($urandom_range(0, 1));
        rwd[m] = $urandom;
        rq[m]  = 1'b1;
    endtask

    logic [31:0] err_addr[3];
    logic [2:0]  err_size[3];
    int          base;

    initial begin
        for (int m = 0; m < 2; m++) begin
            rq[m] = 1'b0; rwe[m] = 1'b0; rsg[m] = 1'b0;
            rad[m] = '0; rwd[m] = '0; rsz[m] = 3'd4;
            got_rv[m] = 1'b0; got_err[m] = 1'b0; got_data[m] = '0;
            gnt_seen[m] = 1'b0; gnt_cyc[m] = 0; rv_cyc[m] = 0;
        end
        rst_n = 1'b0;
        issue(0, 1'b0, 32'h40, 32'h0, 3'd4, 1'b0);
        issue(1, 1'b0, 32'h44, 32'h0, 3'd4, 1'b0);
        keep_req = 1'b1;
        @(negedge clk);
        step();
        step();
        check("rst_no_rvalid", 64'(rv_cnt), 64'(0));
        check("rst_no_strobe", 64'(strobe_cnt), 64'(0));
        check("rst_no_gnt", 64'(glog_m.size()), 64'(0));

        rst_n = 1'b1;
        for (int i = 0; i < 14 && glog_m.size() < 4; i++) step();
        check("alt_count", 64'(glog_m.size()), 64'(4));
        for (int i = 0; i < glog_m.size() && i < 4; i++) begin
            check("alt_master", 64'(glog_m[i]), 64'(FIXED_PRIO ? 0 : i % 2));
            if (i > 0) check("alt_gap", 64'(glog_c[i] - glog_c[i-1]), 64'(3));
        end
        keep_req = 1'b0;
        rq[0] = 1'b0;
        rq[1] = 1'b0;
        repeat (4) step();

        issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'd4, 1'b0);
        wait_resp(0, "st4");
        check("st4_err", 64'(got_err[0]), 64'(0));
        check("st4_rdata", 64'(got_data[0]), 64'(0));
        issue(0, 1'b0, 32'h13, 32'h0, 3'd1, 1'b1);
        wait_resp(0, "ld1s");
        check("ld1s_rdata", 64'(got_data[0]), 64'(32'hFFFF_FFDE));
        check("ld1s_latency", 64'(rv_cyc[0] - gnt_cyc[0]), 64'(2));

        err_addr[0] = 32'h10;            err_size[0] = 3'd3;
        err_addr[1] = 32'h11;            err_size[1] = 3'd2;
        err_addr[2] = MEM_BYTES - 2;     err_size[2] = 3'd4;
        for (int k = 0; k < 3; k++) begin
            base = strobe_cnt;
            issue(0, 1'($urandom_range(0, 1)), err_addr[k], 32'h1234_5678, err_size[k], 1'b0);
            wait_resp(0, "err");
            check("err_flag", 64'(got_err[0]), 64'(1));
            check("err_rdata", 64'(got_data[0]), 64'(0));
            check("err_no_strobe", 64'(strobe_cnt - base), 64'(0));
        end
        issue(0, 1'b1, MEM_BYTES - 4, 32'hCAFE_F00D, 3'd4, 1'b0);
        wait_resp(0, "top_word");
        check("top_word_err", 64'(got_err[0]), 64'(0));

        issue(1, 1'b1, 32'h20, 32'h1234_ABCD, 3'd2, 1'b0);
        wait_resp(1, "m1_st2");
        check("m1_st2_ack", 64'({got_err[1], got_data[1]}), 64'(0));
        issue(1, 1'b0, 32'h20, 32'h0, 3'd2, 1'b0);
        wait_resp(1, "m1_ld2");
        check("m1_ld2_zext", 64'(got_data[1]), 64'(32'h0000_ABCD));

        issue(0, 1'b0, 32'h10, 32'h0, 3'd4, 1'b0);
        for (int i = 0; i < 10 && !gnt_seen[0]; i++) step();
        check("abort_gnt", 64'(gnt_seen[0]), 64'(1));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        base = rv_cnt;
        repeat (4) step();
        check("abort_no_rvalid", 64'(rv_cnt - base), 64'(0));
        issue(0, 1'b0, 32'h10, 32'h0, 3'd4, 1'b0);
        wait_resp(0, "after_abort");
        check("after_abort_rdata", 64'(got_data[0]), 64'(32'hDEAD_BEEF));

        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!rq[m]) begin
                    if ($urandom_range(0, 3) == 0) gen(m);
                end else if ($urandom_range(0, 31) == 0) begin
                    rq[m] = 1'b0;
                end
            end
            step();
        end
        rq[0] = 1'b0;
        rq[1] = 1'b0;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
